// File: rtl/seg_pkg.sv
// Shared definitions for segment-display blocks: hex glyphs {g,f,e,d,c,b,a}
// (active-high) and the arbiter state encoding.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] SEG_0 = 7'b0111111;
   localparam logic [6:0] SEG_1 = 7'b0000110;
   localparam logic [6:0] SEG_2 = 7'b1011011;
   localparam logic [6:0] SEG_3 = 7'b1001111;
   localparam logic [6:0] SEG_4 = 7'b1100110;
   localparam logic [6:0] SEG_5 = 7'b1101101;
   localparam logic [6:0] SEG_6 = 7'b1111101;
   localparam logic [6:0] SEG_7 = 7'b0000111;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1101111;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b1111100;
   localparam logic [6:0] SEG_C = 7'b0111001;
   localparam logic [6:0] SEG_D = 7'b1011110;
   localparam logic [6:0] SEG_E = 7'b1111001;
   localparam logic [6:0] SEG_F = 7'b1110001;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/hex7seg.sv
// Pure combinational hex digit to 7-segment decoder, output {g,f,e,d,c,b,a}.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg_req_arbiter.sv
// Round-robin arbiter sharing one 7-segment indicator among 8 requesters,
// with bounded grant tenure and a timeout pulse on forced release.
module seg_req_arbiter
   import seg_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout,
   output logic [6:0] seg
);

   localparam int CNT_W = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_e       state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             timeout_q, timeout_d;
   logic [6:0]       seg_raw;

   // Rotate so bit ptr lands at bit 0, take lowest set bit, rotate back.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [15:0] dbl;
      logic [7:0]  rot;
      logic [2:0]  k;
      dbl = {r, r} >> p;
      rot = dbl[7:0];
      k   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rot[i]) k = 3'(i);
      end
      return k + p;
   endfunction

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            gnt_d = 8'h00;
            idx_d = 3'd0;
            if (en && (req != 8'h00)) begin
               idx_d   = rr_pick(req, ptr_q);
               gnt_d   = 8'h01 << rr_pick(req, ptr_q);
               hold_d  = '0;
               state_d = ST_GRANT;
            end
         end
         default: begin
            if (!en || !req[idx_q] || (hold_q == HOLD_LAST)) begin
               // en and a dropped request outrank the timeout report
               timeout_d = en && req[idx_q];
               gnt_d     = 8'h00;
               idx_d     = 3'd0;
               hold_d    = '0;
               ptr_d     = idx_q + 3'd1;
               state_d   = ST_IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         hold_q    <= '0;
         gnt_q     <= 8'h00;
         idx_q     <= 3'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         timeout_q <= timeout_d;
      end
   end

   hex7seg u_hex7seg (
      .hex ({1'b0, idx_q}),
      .seg (seg_raw)
   );

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = |gnt_q;
   assign timeout   = timeout_q;
   assign seg       = gnt_valid ? seg_raw : SEG_BLANK;

endmodule

// File: doc/seg_req_arbiter.md
Name: seg_req_arbiter

Overview:
- Round-robin arbiter that shares one 7-segment display/indicator resource among 8 requesters (switch/key lines).
- Replaces the fixed-priority 8-to-3 encode path in the board top: grants one requester at a time, holds the grant with a bounded tenure, and drives the granted index in binary and as a 7-seg pattern.
- Sits between raw request inputs and the board LEDs/segment pins.

Parameters:
- MAX_HOLD, 16, maximum grant tenure in cycles before forced release; legal range 2..256.
- CNT_W, $clog2(MAX_HOLD), hold-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable; low blocks new grants and revokes the current one.
- req  in  8  request lines; bit i = requester i, level-sensitive.
- gnt  out  8  one-hot grant, registered.
- gnt_idx  out  3  binary index of the granted requester, registered.
- gnt_valid  out  1  high while any grant is held, i.e. gnt != 0.
- timeout  out  1  one-cycle pulse on a forced release by MAX_HOLD.
- seg  out  7  segment pattern {g,f,e,d,c,b,a}, active-high, for gnt_idx; all zero when gnt_valid=0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, seg=0.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0: search starts at ptr and wraps 7->0; the first set bit i wins.
  - Next edge: gnt=1<<i, gnt_idx=i, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled to gnt visible: 1 cycle.
  - Otherwise stay in IDLE with all outputs at their reset values.
- GRANT (holder h=gnt_idx), rules in priority order:
  1. en=0 -> release.
  2. req[h]=0 -> release.
  3. hold_cnt==MAX_HOLD-1 -> release and pulse timeout=1 for the next cycle.
  4. Otherwise hold_cnt++ and hold the grant.
- Release, next edge:
  - gnt=0, gnt_valid=0, gnt_idx=0, state=IDLE, ptr=(h+1) mod 8.
  - No re-arbitration in the release cycle: there is exactly one idle cycle between consecutive grants.
- Tenure: a requester holding req high continuously gets exactly MAX_HOLD cycles with gnt high.
- Wrap-around: ptr after h=7 is 0; hold_cnt never exceeds MAX_HOLD-1.
- Requests from others during GRANT are ignored; they are only evaluated in IDLE.
- Simultaneous en fall and timeout: release happens; timeout is NOT pulsed, because en has priority.
- seg is combinational from the registered gnt_idx/gnt_valid:
  - Patterns 0..7 = 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111.
  - seg=0000000 when gnt_valid=0.
- No X on outputs after reset; req may change at any cycle and is assumed synchronous to clk (synchronisers are external).

Decomposition:
- Shared package seg_pkg:
  - 7-seg pattern constants for hex 0..F.
  - SEG_BLANK = 7'b0.
  - State enum localparams ST_IDLE, ST_GRANT.
- Sub-module hex7seg (4-bit in, 7-bit out, pure combinational).
  - Instantiated with {1'b0,gnt_idx}; the output is gated by gnt_valid.
  - Reusable by later display blocks.
- Round-robin pick is a function inside seg_req_arbiter (rotate req by ptr, find-first-set, rotate back); no separate module.

Test Plan:
- Reset/idle:
  - Stimulus: rst pulse mid-cycle while gnt=8'h04.
  - Response: gnt, gnt_idx, gnt_valid, seg all 0 immediately; ptr=0 afterwards.
- Single request:
  - Stimulus: en=1, req=8'h20 at cycle 0, dropped at cycle 5.
  - Response: gnt=8'h20, gnt_idx=5, seg=1101101 from cycle 1; released 1 cycle after the drop.
- Round-robin:
  - Stimulus: req=8'h81 held, MAX_HOLD=4.
  - Response, sequence of grants: idx0 for 4 cycles with timeout, 1 idle cycle, idx7 for 4 cycles with timeout, 1 idle cycle, then idx0 again (ptr wraps 7->0).
- Timeout boundary:
  - Stimulus: MAX_HOLD=16, req=8'h02 held.
  - Response: gnt high exactly 16 cycles; timeout=1 for exactly one cycle, concurrent with gnt_valid falling.
- Enable revoke:
  - Stimulus: en dropped in the same cycle hold_cnt==MAX_HOLD-1.
  - Response: released next edge, timeout stays 0, no new grant while en=0 even with req=8'hFF.
- No-request/disabled:
  - Stimulus: en=0, req=8'hFF for 20 cycles.
  - Response: gnt_valid=0, seg=0000000 throughout.
